// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared defaults, colours and sequencer encoding for the paddle bank
package paddle_pkg;
  localparam int NUM_PADDLES_DEF = 2;
  localparam int PADDLE_LEN_DEF  = 21;
  localparam int X_W_DEF         = 8;
  localparam int Y_W_DEF         = 7;
  localparam int STEP_DEF        = 1;
  localparam int Y_TOP_MIN_DEF   = 31;
  localparam int Y_TOP_MAX_DEF   = 98;
  localparam int Y_INIT_DEF      = 75;

  localparam logic [2:0] COL_DRAW  = 3'b111;
  localparam logic [2:0] COL_ERASE = 3'b000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
endpackage

// File: rtl/paddle_axis.sv
// rtl/paddle_axis.sv - one paddle's saturating top-edge y register
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int Y_W       = Y_W_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int Y_TOP_MIN = Y_TOP_MIN_DEF,
  parameter int Y_TOP_MAX = Y_TOP_MAX_DEF,
  parameter int Y_INIT    = Y_INIT_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           tick_en,
  input  logic           inc,
  input  logic           dec,
  output logic [Y_W-1:0] y
);
  localparam logic [Y_W:0]   STEP_X = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]   MIN_X  = (Y_W+1)'(Y_TOP_MIN);
  localparam logic [Y_W:0]   MAX_X  = (Y_W+1)'(Y_TOP_MAX);
  localparam logic [Y_W-1:0] INIT_V = Y_W'(Y_INIT);

  logic [Y_W:0] y_x;
  logic [Y_W:0] up_sum;
  logic [Y_W:0] up_sat;
  logic [Y_W:0] down_sat;

  // One spare bit keeps both directions free of wrap-around before clamping
  assign y_x      = {1'b0, y};
  assign up_sum   = y_x + STEP_X;
  assign up_sat   = (up_sum > MAX_X) ? MAX_X : up_sum;
  assign down_sat = (y_x < MIN_X + STEP_X) ? MIN_X : (y_x - STEP_X);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y <= INIT_V;
    end else if (tick_en && (inc ^ dec)) begin
      y <= inc ? up_sat[Y_W-1:0] : down_sat[Y_W-1:0];
    end
  end
endmodule

// File: rtl/paddle_bank.sv
// rtl/paddle_bank.sv - paddle position bank with single-pass pixel draw sequencer
module paddle_bank
  import paddle_pkg::*;
#(
  parameter int NUM_PADDLES = NUM_PADDLES_DEF,
  parameter int PADDLE_LEN  = PADDLE_LEN_DEF,
  parameter int X_W         = X_W_DEF,
  parameter int Y_W         = Y_W_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int Y_TOP_MIN   = Y_TOP_MIN_DEF,
  parameter int Y_TOP_MAX   = Y_TOP_MAX_DEF,
  parameter int Y_INIT      = Y_INIT_DEF,
  parameter logic [NUM_PADDLES*X_W-1:0] X_LIST = {8'd155, 8'd5}
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       tick,
  input  logic                       move_en,
  input  logic [NUM_PADDLES-1:0]     inc,
  input  logic [NUM_PADDLES-1:0]     dec,
  input  logic                       draw_start,
  input  logic                       erase,
  output logic [NUM_PADDLES*X_W-1:0] paddle_x,
  output logic [NUM_PADDLES*Y_W-1:0] paddle_y,
  output logic [X_W-1:0]             x_out,
  output logic [Y_W-1:0]             y_out,
  output logic [2:0]                 colour_out,
  output logic                       pixel_valid,
  output logic                       busy,
  output logic                       draw_done
);
  localparam int P_W = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
  localparam int R_W = $clog2(PADDLE_LEN + 1);

  logic                       tick_en;
  logic [1:0]                 state;
  logic [P_W-1:0]             p;
  logic [R_W-1:0]             r;
  logic [P_W-1:0]             np;
  logic [R_W-1:0]             nr;
  logic                       last_row;
  logic                       last_p;
  logic [NUM_PADDLES*Y_W-1:0] snap_y;

  assign tick_en  = tick & move_en;
  assign paddle_x = X_LIST;

  for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_axis
    paddle_axis #(
      .Y_W       (Y_W),
      .STEP      (STEP),
      .Y_TOP_MIN (Y_TOP_MIN),
      .Y_TOP_MAX (Y_TOP_MAX),
      .Y_INIT    (Y_INIT)
    ) u_axis (
      .clk     (clk),
      .resetn  (resetn),
      .tick_en (tick_en),
      .inc     (inc[gi]),
      .dec     (dec[gi]),
      .y       (paddle_y[gi*Y_W +: Y_W])
    );
  end

  assign last_row = (r == R_W'(PADDLE_LEN - 1));
  assign last_p   = (p == P_W'(NUM_PADDLES - 1));

  always_comb begin
    np = p;
    nr = r + 1'b1;
    if (last_row) begin
      np = p + 1'b1;
      nr = '0;
    end
  end

  // p/r name the pixel currently on x_out/y_out; outputs are registered one step ahead
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      p           <= '0;
      r           <= '0;
      snap_y      <= '0;
      x_out       <= '0;
      y_out       <= '0;
      colour_out  <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      draw_done   <= 1'b0;
    end else begin
      draw_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (draw_start) begin
            state       <= ST_STREAM;
            snap_y      <= paddle_y;
            colour_out  <= erase ? COL_ERASE : COL_DRAW;
            p           <= '0;
            r           <= '0;
            x_out       <= X_LIST[X_W-1:0];
            y_out       <= paddle_y[Y_W-1:0];
            pixel_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (last_row && last_p) begin
            state       <= ST_DONE;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            draw_done   <= 1'b1;
          end else begin
            p     <= np;
            r     <= nr;
            x_out <= X_LIST[np*X_W +: X_W];
            y_out <= snap_y[np*Y_W +: Y_W] + Y_W'(nr);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_paddle_bank.sv
// tb/tb_paddle_bank.sv - directed self-checking bench for paddle_bank
module tb_paddle_bank;
  logic        clk = 1'b0;
  logic        resetn;
  logic        tick, move_en, draw_start, erase;
  logic [1:0]  inc, dec;
  logic [15:0] paddle_x;
  logic [13:0] paddle_y;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        pixel_valid, busy, draw_done;

  logic        tick7;
  logic [1:0]  inc7, dec7;
  logic [15:0] p7_x;
  logic [13:0] p7_y;
  logic [7:0]  x7_out;
  logic [6:0]  y7_out;
  logic [2:0]  c7_out;
  logic        v7, b7, d7;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  paddle_bank dut (
    .clk(clk), .resetn(resetn), .tick(tick), .move_en(move_en),
    .inc(inc), .dec(dec), .draw_start(draw_start), .erase(erase),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .pixel_valid(pixel_valid), .busy(busy),
    .draw_done(draw_done)
  );

  paddle_bank #(.STEP(7), .Y_INIT(95)) dut7 (
    .clk(clk), .resetn(resetn), .tick(tick7), .move_en(1'b1),
    .inc(inc7), .dec(dec7), .draw_start(1'b0), .erase(1'b0),
    .paddle_x(p7_x), .paddle_y(p7_y), .x_out(x7_out), .y_out(y7_out),
    .colour_out(c7_out), .pixel_valid(v7), .busy(b7), .draw_done(d7)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    resetn = 1'b0; tick = 0; move_en = 1; draw_start = 0; erase = 0;
    inc = 0; dec = 0; tick7 = 0; inc7 = 0; dec7 = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_tick(input logic [1:0] i, input logic [1:0] d);
    @(negedge clk);
    inc = i; dec = d; tick = 1'b1;
    @(negedge clk);
    inc = 0; dec = 0; tick = 1'b0;
  endtask

  task automatic do_tick7(input logic [1:0] i, input logic [1:0] d);
    @(negedge clk);
    inc7 = i; dec7 = d; tick7 = 1'b1;
    @(negedge clk);
    inc7 = 0; dec7 = 0; tick7 = 1'b0;
  endtask

  // Called in the cycle carrying pixel 0; walks the full pass and the done pulse
  task automatic stream_pass(input logic [6:0] y0e, input logic [6:0] y1e,
                             input logic [2:0] col, input string tag);
    logic [7:0] ex;
    logic [6:0] ey;
    for (int k = 0; k < 42; k++) begin
      ex = (k >= 21) ? 8'd155 : 8'd5;
      ey = ((k >= 21) ? y1e : y0e) + 7'(k % 21);
      n_checks++;
      if ({pixel_valid, busy, x_out, y_out, colour_out} !== {1'b1, 1'b1, ex, ey, col})
        $display("FAIL %s pixel %0d: got v=%b b=%b x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                 tag, k, pixel_valid, busy, x_out, y_out, colour_out, ex, ey, col);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({pixel_valid, busy, draw_done} !== 3'b001)
      $display("FAIL %s done cycle: got v/b/d=%b%b%b want 001", tag, pixel_valid, busy, draw_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({pixel_valid, busy, draw_done} !== 3'b000)
      $display("FAIL %s after done: got v/b/d=%b%b%b want 000", tag, pixel_valid, busy, draw_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick = 0; move_en = 1; draw_start = 0; erase = 0;
    inc = 0; dec = 0; tick7 = 0; inc7 = 0; dec7 = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({paddle_y, pixel_valid, busy, draw_done, x_out, y_out, colour_out} !==
        {7'd75, 7'd75, 3'b000, 8'd0, 7'd0, 3'd0})
      $display("FAIL reset_state: got y=%h v/b/d=%b%b%b x=%0d y=%0d c=%0d want y=25cb zeros",
               paddle_y, pixel_valid, busy, draw_done, x_out, y_out, colour_out);
    else n_pass++;
    n_checks++;
    if (paddle_x !== {8'd155, 8'd5})
      $display("FAIL paddle_x: got %h want 9b05", paddle_x);
    else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_draw();
    @(negedge clk);
    draw_start = 1'b1;
    @(negedge clk);
    draw_start = 1'b0;
    stream_pass(7'd75, 7'd75, 3'b111, "first_draw");
  endtask

  task automatic test_step7();
    do_tick7(2'b01, 2'b00);
    n_checks++;
    if (p7_y !== {7'd95, 7'd98}) $display("FAIL step7_inc_sat: got %h want {95,98}", p7_y);
    else n_pass++;
    for (int i = 1; i <= 10; i++) begin
      do_tick7(2'b00, 2'b10);
      if (i == 9) begin
        n_checks++;
        if (p7_y[13:7] !== 7'd32) $display("FAIL step7_dec9: got %0d want 32", p7_y[13:7]);
        else n_pass++;
      end
    end
    n_checks++;
    if (p7_y[13:7] !== 7'd31) $display("FAIL step7_dec_sat: got %0d want 31", p7_y[13:7]);
    else n_pass++;
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 30; i++) begin
      do_tick(2'b01, 2'b00);
      if (i == 22) begin
        n_checks++;
        if (paddle_y[6:0] !== 7'd97) $display("FAIL inc_22: got %0d want 97", paddle_y[6:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (paddle_y !== {7'd75, 7'd98}) $display("FAIL inc_sat: got %h want {75,98}", paddle_y);
    else n_pass++;
    for (int i = 1; i <= 50; i++) begin
      do_tick(2'b00, 2'b10);
      if (i == 43) begin
        n_checks++;
        if (paddle_y[13:7] !== 7'd32) $display("FAIL dec_43: got %0d want 32", paddle_y[13:7]);
        else n_pass++;
      end
    end
    n_checks++;
    if (paddle_y !== {7'd31, 7'd98}) $display("FAIL dec_sat: got %h want {31,98}", paddle_y);
    else n_pass++;
  endtask

  task automatic test_hold();
    do_tick(2'b11, 2'b11);
    n_checks++;
    if (paddle_y !== {7'd31, 7'd98}) $display("FAIL both_set_hold: got %h want {31,98}", paddle_y);
    else n_pass++;
    move_en = 1'b0;
    do_tick(2'b10, 2'b01);
    n_checks++;
    if (paddle_y !== {7'd31, 7'd98}) $display("FAIL move_en_off: got %h want {31,98}", paddle_y);
    else n_pass++;
    move_en = 1'b1;
    do_tick(2'b10, 2'b01);
    n_checks++;
    if (paddle_y !== {7'd32, 7'd97}) $display("FAIL move_en_on: got %h want {32,97}", paddle_y);
    else n_pass++;
  endtask

  task automatic test_snapshot();
    do_reset();
    @(negedge clk);
    draw_start = 1'b1; tick = 1'b1; inc = 2'b01;
    @(negedge clk);
    draw_start = 1'b0; tick = 1'b0; inc = 2'b00;
    n_checks++;
    if (paddle_y !== {7'd75, 7'd76}) $display("FAIL snapshot_live_y: got %h want {75,76}", paddle_y);
    else n_pass++;
    stream_pass(7'd75, 7'd75, 3'b111, "snapshot");
  endtask

  task automatic test_back_to_back();
    int starts[$];
    int valid_cnt = 0;
    int col_bad = 0;
    logic prev = 1'b0;
    @(negedge clk);
    draw_start = 1'b1; erase = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (pixel_valid && !prev) starts.push_back(cyc);
      if (pixel_valid) begin
        valid_cnt++;
        if (colour_out !== 3'b000) col_bad++;
      end
      prev = pixel_valid;
    end
    draw_start = 1'b0; erase = 1'b0;
    n_checks++;
    if (starts.size() !== 3) $display("FAIL b2b_pass_count: got %0d want 3", starts.size());
    else n_pass++;
    if (starts.size() >= 2) begin
      n_checks++;
      if (starts[0] !== 1) $display("FAIL b2b_first_start: got %0d want 1", starts[0]);
      else n_pass++;
      n_checks++;
      if (starts[1] - starts[0] !== 44)
        $display("FAIL b2b_spacing: got %0d want 44", starts[1] - starts[0]);
      else n_pass++;
    end
    n_checks++;
    if (valid_cnt !== 96) $display("FAIL b2b_pixel_count: got %0d want 96", valid_cnt);
    else n_pass++;
    n_checks++;
    if (col_bad !== 0) $display("FAIL erase_colour: got %0d nonzero pixels want 0", col_bad);
    else n_pass++;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_drain: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pass();
    int done_seen = 0;
    do_reset();
    @(negedge clk);
    draw_start = 1'b1;
    @(negedge clk);
    draw_start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({pixel_valid, x_out, y_out} !== {1'b1, 8'd5, 7'd85})
      $display("FAIL pixel10: got v=%b x=%0d y=%0d want v=1 x=5 y=85", pixel_valid, x_out, y_out);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({pixel_valid, busy, draw_done, x_out, y_out, colour_out} !== 21'd0)
      $display("FAIL async_reset: got v/b/d=%b%b%b x=%0d y=%0d c=%0d want zeros",
               pixel_valid, busy, draw_done, x_out, y_out, colour_out);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (draw_done || pixel_valid) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) $display("FAIL no_done_after_reset: got %0d active cycles want 0", done_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_step7();
    test_saturate();
    test_hold();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
